// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged power-on / soft / watchdog reset sequencer
//
// Releases NUM_STAGES reset outputs one after another: first after a
// power-on delay, then after a hold following a soft or watchdog reset.
// Ports:
//   clk       system clock
//   reset     asynchronous active-high external reset
//   soft_rst  synchronous soft-reset request (acted on only in RUN)
//   wdt_kick  synchronous watchdog restart (ignored when WDT_TIMEOUT = 0)
//   rst_out   active-high stage resets, bit 0 released first
//   ready     high once every stage is released
//   cause     last reset cause: 0 POR/external, 1 soft, 2 watchdog
module reset_sequencer #(
   parameter int NUM_STAGES  = 3,
   parameter int POR_CYCLES  = 255,
   parameter int STAGE_DELAY = 16,
   parameter int HOLD_CYCLES = 16,
   parameter int WDT_TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  soft_rst,
   input  logic                  wdt_kick,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  ready,
   output logic [1:0]            cause
);

   localparam int MAX_PH    = (POR_CYCLES > STAGE_DELAY) ? POR_CYCLES : STAGE_DELAY;
   localparam int MAX_DELAY = (MAX_PH > HOLD_CYCLES) ? MAX_PH : HOLD_CYCLES;
   localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
   localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      SYNC     = 3'd0,
      POR_WAIT = 3'd1,
      HOLD     = 3'd2,
      STAGE    = 3'd3,
      RUN      = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            sync_q, sync_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
   logic                  ready_q, ready_d;
   logic [1:0]            cause_q, cause_d;
   logic                  rst_sync;
   logic                  wait_done;
   logic                  wdt_expire;

   // Assertion is asynchronous via the flop reset; only release is synchronised.
   assign sync_d   = {sync_q[0], 1'b0};
   assign rst_sync = sync_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q    <= 2'b11;
         state_q   <= SYNC;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= '1;
         ready_q   <= 1'b0;
         cause_q   <= 2'd0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
         cause_q   <= cause_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      ready_d   = ready_q;
      cause_d   = cause_q;
      wait_done = 1'b0;

      case (state_q)
         SYNC: begin
            if (!rst_sync) begin
               state_d = POR_WAIT;
               cnt_d   = '0;
            end
         end

         // Power-on wait and post-trigger hold differ only in their length.
         POR_WAIT, HOLD: begin
            wait_done = (state_q == POR_WAIT) ? (cnt_q == POR_LAST) : (cnt_q == HOLD_LAST);
            if (wait_done) begin
               rst_out_d[0] = 1'b0;
               cnt_d        = '0;
               idx_d        = IDX_W'(1);
               if (NUM_STAGES == 1) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d = STAGE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         STAGE: begin
            if (cnt_q == STAGE_LAST) begin
               cnt_d = '0;
               for (int i = 0; i < NUM_STAGES; i++) begin
                  if (IDX_W'(i) == idx_q) rst_out_d[i] = 1'b0;
               end
               if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RUN: begin
            // Soft request outranks a simultaneous watchdog expiry.
            if (soft_rst || wdt_expire) begin
               state_d   = HOLD;
               cnt_d     = '0;
               idx_d     = '0;
               rst_out_d = '1;
               ready_d   = 1'b0;
               cause_d   = soft_rst ? 2'd1 : 2'd2;
            end
         end

         default: begin
            state_d = SYNC;
         end
      endcase
   end

   generate
      if (WDT_TIMEOUT > 0) begin : g_wdt
         localparam int WDT_W = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;
         localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

         logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
         logic             wdt_hit;

         assign wdt_hit    = (wdt_cnt_q == WDT_LAST);
         // A kick on the expiry cycle wins and simply restarts the count.
         assign wdt_expire = (state_q == RUN) && wdt_hit && !wdt_kick;

         // Held at zero outside RUN so every entry to RUN starts a fresh period;
         // saturates at the limit, the trigger takes the FSM out of RUN anyway.
         always_comb begin
            wdt_cnt_d = wdt_cnt_q;
            if (state_q != RUN || wdt_kick) begin
               wdt_cnt_d = '0;
            end else if (!wdt_hit) begin
               wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) wdt_cnt_q <= '0;
            else       wdt_cnt_q <= wdt_cnt_d;
         end
      end else begin : g_no_wdt
         logic unused_wdt_kick;
         assign unused_wdt_kick = wdt_kick;
         assign wdt_expire      = 1'b0;
      end
   endgenerate

   assign rst_out = rst_out_q;
   assign ready   = ready_q;
   assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer
module tb_reset_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_soft, a_kick, w_soft, w_kick, p_soft, p_kick;
   logic [2:0] a_rst, w_rst;
   logic [0:0] p_rst;
   logic       a_rdy, w_rdy, p_rdy;
   logic [1:0] a_cause, w_cause, p_cause;

   int vectors     = 0;
   int miscompares = 0;
   int edge_cnt    = 0;
   int base        = 0;

   // Defaults, watchdog disabled.
   reset_sequencer dut_a (
      .clk(clk), .reset(reset), .soft_rst(a_soft), .wdt_kick(a_kick),
      .rst_out(a_rst), .ready(a_rdy), .cause(a_cause)
   );

   // Defaults with WDT_TIMEOUT = 100.
   reset_sequencer #(.WDT_TIMEOUT(100)) dut_w (
      .clk(clk), .reset(reset), .soft_rst(w_soft), .wdt_kick(w_kick),
      .rst_out(w_rst), .ready(w_rdy), .cause(w_cause)
   );

   // Minimum-size corner configuration.
   reset_sequencer #(
      .NUM_STAGES(1), .POR_CYCLES(1), .STAGE_DELAY(1),
      .HOLD_CYCLES(2), .WDT_TIMEOUT(4)
   ) dut_p (
      .clk(clk), .reset(reset), .soft_rst(p_soft), .wdt_kick(p_kick),
      .rst_out(p_rst), .ready(p_rdy), .cause(p_cause)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      edge_cnt++;
   endtask

   task automatic adv(input int k);
      while (edge_cnt < base + k) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset  = 1'b0;
      a_soft = 1'b0; a_kick = 1'b0;
      w_soft = 1'b0; w_kick = 1'b1;
      p_soft = 1'b0; p_kick = 1'b1;

      // Power-on: reset takes effect without a clock edge.
      #2 reset = 1'b1;
      #1;
      chk("por_async_rst", a_rst, 3'b111);
      chk("por_async_rdy", a_rdy, 1'b0);
      chk("por_async_cause", a_cause, 2'd0);
      repeat (3) tick();
      reset = 1'b0;
      // Two synchroniser edges, third edge is T0.
      tick(); tick(); tick();
      base = edge_cnt;
      chk("t0_a_rst", a_rst, 3'b111);
      chk("t0_p_rst", p_rst, 1'b1);
      chk("t0_p_rdy", p_rdy, 1'b0);
      adv(1);
      chk("sweep_p_rst", p_rst, 1'b0);
      chk("sweep_p_rdy", p_rdy, 1'b1);
      chk("sweep_p_cause", p_cause, 2'd0);
      adv(254);
      chk("por_254", a_rst, 3'b111);
      adv(255);
      chk("por_255", a_rst, 3'b110);
      // Soft request during STAGE is ignored.
      adv(259);
      a_soft = 1'b1;
      adv(260);
      a_soft = 1'b0;
      chk("stage_soft_rst", a_rst, 3'b110);
      chk("stage_soft_cause", a_cause, 2'd0);
      adv(270);
      chk("por_270", a_rst, 3'b110);
      adv(271);
      chk("por_271", a_rst, 3'b100);
      adv(286);
      chk("por_286_rdy", a_rdy, 1'b0);
      adv(287);
      chk("por_287_rst", a_rst, 3'b000);
      chk("por_287_rdy", a_rdy, 1'b1);
      chk("por_287_cause", a_cause, 2'd0);
      chk("por_287_w_rst", w_rst, 3'b000);
      chk("por_287_w_rdy", w_rdy, 1'b1);

      // Soft reset in RUN.
      adv(300);
      a_soft = 1'b1;
      tick();
      a_soft = 1'b0;
      base = edge_cnt;
      chk("soft_trig_rst", a_rst, 3'b111);
      chk("soft_trig_rdy", a_rdy, 1'b0);
      chk("soft_trig_cause", a_cause, 2'd1);
      adv(15);
      chk("soft_15", a_rst, 3'b111);
      adv(16);
      chk("soft_16", a_rst, 3'b110);
      adv(47);
      chk("soft_47_rst", a_rst, 3'b100);
      chk("soft_47_rdy", a_rdy, 1'b0);
      adv(48);
      chk("soft_48_rst", a_rst, 3'b000);
      chk("soft_48_rdy", a_rdy, 1'b1);
      chk("soft_48_cause", a_cause, 2'd1);

      // Watchdog: kick every 50 cycles for 1000 cycles.
      for (int i = 0; i < 20; i++) begin
         w_kick = 1'b1;
         tick();
         w_kick = 1'b0;
         repeat (49) tick();
         chk("wdt_kicked_rdy", w_rdy, 1'b1);
      end
      base = edge_cnt - 49;
      adv(99);
      chk("wdt_99_rdy", w_rdy, 1'b1);
      adv(100);
      chk("wdt_100_rst", w_rst, 3'b111);
      chk("wdt_100_rdy", w_rdy, 1'b0);
      chk("wdt_100_cause", w_cause, 2'd2);
      adv(148);
      chk("wdt_rerun_rdy", w_rdy, 1'b1);
      // Kick on the expiry edge: no trigger, period restarts.
      base = base + 148;
      adv(99);
      w_kick = 1'b1;
      adv(100);
      w_kick = 1'b0;
      chk("kick_at_expiry_rdy", w_rdy, 1'b1);
      chk("kick_at_expiry_rst", w_rst, 3'b000);
      adv(199);
      chk("wdt_after_kick_199", w_rdy, 1'b1);
      adv(200);
      chk("wdt_after_kick_200", w_rdy, 1'b0);
      chk("wdt_after_kick_cause", w_cause, 2'd2);

      // Async reset in the middle of HOLD, between clock edges.
      base = base + 200;
      adv(5);
      #3 reset = 1'b1;
      #1;
      chk("hold_async_rst", w_rst, 3'b111);
      chk("hold_async_rdy", w_rdy, 1'b0);
      chk("hold_async_cause", w_cause, 2'd0);
      chk("hold_async_a_cause", a_cause, 2'd0);
      repeat (2) tick();
      reset = 1'b0;
      tick(); tick(); tick();
      base = edge_cnt;
      adv(254);
      chk("repor_254", w_rst, 3'b111);
      adv(255);
      chk("repor_255", w_rst, 3'b110);
      adv(287);
      chk("repor_287_rst", w_rst, 3'b000);
      chk("repor_287_rdy", w_rdy, 1'b1);
      chk("repor_287_cause", w_cause, 2'd0);

      // Corner config: soft together with watchdog expiry, then plain expiry.
      base   = edge_cnt;
      p_kick = 1'b0;
      adv(3);
      chk("p_pre_expiry_rdy", p_rdy, 1'b1);
      p_soft = 1'b1;
      adv(4);
      p_soft = 1'b0;
      chk("p_soft_wdt_rst", p_rst, 1'b1);
      chk("p_soft_wdt_rdy", p_rdy, 1'b0);
      chk("p_soft_wdt_cause", p_cause, 2'd1);
      adv(5);
      chk("p_hold_5", p_rst, 1'b1);
      adv(6);
      chk("p_hold_6_rst", p_rst, 1'b0);
      chk("p_hold_6_rdy", p_rdy, 1'b1);
      adv(9);
      chk("p_wdt_9_rdy", p_rdy, 1'b1);
      adv(10);
      chk("p_wdt_10_rdy", p_rdy, 1'b0);
      chk("p_wdt_10_cause", p_cause, 2'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
